// File: rtl/mips_mc_control.sv
// mips_mc_control
//   Multi-cycle control unit for the MIPS core. A Moore FSM steps each
//   instruction through fetch, decode, execute, memory access and write-back.
//   The datapath selects and write strobes are decoded from the registered
//   state. Two inputs also reach the outputs directly: mem_ready qualifies the
//   FETCH load strobes, and opcode drives illegal_op in DECODE and ext_mode.
//
//   Optional feature macro: MIPS_LOGIC_IMM_EN
//     Adds andi (0x0C), ori (0x0D) and lui (0x0F) through IEXEC/IWB, together
//     with the matching extender modes. When the macro is undefined, ext_mode
//     is constant 00.
//
// Ports
//   clk, reset_n       clock (rising edge), asynchronous active-low reset
//   opcode[5:0]        IR[31:26], stable from DECODE until the next FETCH
//   mem_ready          memory completes the current access this cycle
//   pc_write           unconditional PC load
//   pc_write_cond      branch-qualified PC load
//   iord               memory address select (0 = PC, 1 = ALUOut)
//   mem_read           memory read strobe
//   mem_write          memory write strobe
//   ir_write           instruction register load
//   reg_dst            register write address (0 = rt, 1 = rd)
//   mem_to_reg         register write data (0 = ALUOut, 1 = MDR)
//   reg_write          register-file write
//   alu_src_a          ALU A select (0 = PC, 1 = A)
//   alu_src_b[1:0]     ALU B select (00 = B, 01 = 4, 10 = ext, 11 = ext<<2)
//   alu_op[2:0]        000 add, 001 sub, 010 funct, 011 and, 100 or, 101 pass B
//   pc_src[1:0]        00 = ALU result, 01 = ALUOut, 10 = jump target
//   ext_mode[1:0]      00 = sign, 01 = zero, 10 = imm<<16
//   illegal_op         one-cycle pulse in DECODE on an undecoded opcode
//   state[3:0]         current FSM state, for debug
//
// Handshake: mem_ready is sampled only in FETCH, MEMRD and MEMWR. Each of
// these states holds, with its strobe and iord unchanged, until mem_ready=1.
// The access completes in the first cycle that mem_ready=1.
module mips_mc_control (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic [1:0] ext_mode,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t state_q;

  // Opcode classification
  logic op_lw, op_sw, op_rtype, op_beq, op_addi, op_j, op_imm;
  assign op_lw    = (opcode == 6'h23);
  assign op_sw    = (opcode == 6'h2B);
  assign op_rtype = (opcode == 6'h00);
  assign op_beq   = (opcode == 6'h04);
  assign op_addi  = (opcode == 6'h08);
  assign op_j     = (opcode == 6'h02);

  logic [2:0] imm_alu_op;
  logic [1:0] ext_dec;

`ifdef MIPS_LOGIC_IMM_EN
  logic op_andi, op_ori, op_lui;
  assign op_andi = (opcode == 6'h0C);
  assign op_ori  = (opcode == 6'h0D);
  assign op_lui  = (opcode == 6'h0F);
  assign op_imm  = op_addi | op_andi | op_ori | op_lui;

  always_comb begin
    imm_alu_op = 3'b000;
    ext_dec    = 2'b00;
    if (op_andi) begin
      imm_alu_op = 3'b011;
      ext_dec    = 2'b01;
    end else if (op_ori) begin
      imm_alu_op = 3'b100;
      ext_dec    = 2'b01;
    end else if (op_lui) begin
      imm_alu_op = 3'b101;
      ext_dec    = 2'b10;
    end
  end
`else
  assign op_imm     = op_addi;
  assign imm_alu_op = 3'b000;
  assign ext_dec    = 2'b00;
`endif

  logic op_legal;
  assign op_legal = op_lw | op_sw | op_rtype | op_beq | op_imm | op_j;

  // State register. Codes 12-15 cannot be reached; the default arm pulls the
  // FSM back to FETCH if one ever appears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          if (op_lw || op_sw)  state_q <= S_MEMADR;
          else if (op_rtype)   state_q <= S_EXEC;
          else if (op_beq)     state_q <= S_BRANCH;
          else if (op_imm)     state_q <= S_IEXEC;
          else if (op_j)       state_q <= S_JUMP;
          else                 state_q <= S_FETCH;
        end
        S_MEMADR: state_q <= op_lw ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) state_q <= S_MEMWB;
        S_MEMWB:  state_q <= S_FETCH;
        S_MEMWR:  if (mem_ready) state_q <= S_FETCH;
        S_EXEC:   state_q <= S_ALUWB;
        S_ALUWB:  state_q <= S_FETCH;
        S_BRANCH: state_q <= S_FETCH;
        S_IEXEC:  state_q <= S_IWB;
        S_IWB:    state_q <= S_FETCH;
        S_JUMP:   state_q <= S_FETCH;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  assign state = state_q;

  // Output decode from the registered state
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    pc_src        = 2'b00;
    illegal_op    = 1'b0;
    ext_mode      = (state_q == S_FETCH) ? 2'b00 : ext_dec;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = ~op_legal;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = imm_alu_op;
      end
      S_IWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      default: begin
      end
    endcase

    // While reset is held, no write strobe may fire. The asynchronous reset
    // already puts the FSM in FETCH, so the remaining outputs show FETCH values.
    if (!reset_n) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control
//   Bench for mips_mc_control. The driver runs one instruction at a time. For
//   each cycle it drives the inputs and pushes the expected output vector into
//   exp_q. A monitor on the falling edge pops that vector and compares it with
//   the DUT outputs. The expected sequences come from an instruction-level
//   reference model: a list of phases per instruction class, plus stall cycles.
module tb_mips_mc_control;

  logic       clk;
  logic       reset_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src, ext_mode;
  logic [2:0] alu_op;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  logic [23:0] exp_q[$];

  mips_mc_control dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_src        (pc_src),
    .ext_mode      (ext_mode),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. The phase numbers are the published state codes:
  // 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXEC,
  // 7 ALUWB, 8 BRANCH, 9 IEXEC, 10 IWB, 11 JUMP.
  function automatic bit is_logic_imm(input logic [5:0] op);
`ifdef MIPS_LOGIC_IMM_EN
    return (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0F);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return (op == 6'h23) || (op == 6'h2B) || (op == 6'h00) || (op == 6'h04) ||
           (op == 6'h08) || (op == 6'h02) || is_logic_imm(op);
  endfunction

  function automatic logic [1:0] model_ext(input logic [5:0] op);
    if (!is_logic_imm(op)) return 2'b00;
    return (op == 6'h0F) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [2:0] model_imm_op(input logic [5:0] op);
    if (op == 6'h0C && is_logic_imm(op)) return 3'b011;
    if (op == 6'h0D && is_logic_imm(op)) return 3'b100;
    if (op == 6'h0F && is_logic_imm(op)) return 3'b101;
    return 3'b000;
  endfunction

  // Vector layout:
  // {pcw, pcwc, iord, mr, mw, irw, rdst, m2r, rw, asa, asb[2], aop[3],
  //  psrc[2], ext[2], ill, state[4]}
  function automatic logic [23:0] exp_vec(input int ph, input logic [5:0] op,
                                          input logic rdy, input logic in_rst);
    logic pcw, pcwc, io, mr, mw, irw, rdst, m2r, rw, asa, ill;
    logic [1:0] asb, psrc, ext;
    logic [2:0] aop;
    {pcw, pcwc, io, mr, mw, irw, rdst, m2r, rw, asa, ill} = '0;
    asb = 2'b00; psrc = 2'b00; aop = 3'b000;
    ext = (ph == 0) ? 2'b00 : model_ext(op);
    case (ph)
      0:  begin mr = 1; asb = 2'b01; irw = rdy & ~in_rst; pcw = rdy & ~in_rst; end
      1:  begin asb = 2'b11; ill = ~is_legal(op); end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; io = 1; end
      6:  begin asa = 1; aop = 3'b010; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; aop = 3'b001; pcwc = 1; psrc = 2'b01; end
      9:  begin asa = 1; asb = 2'b10; aop = model_imm_op(op); end
      10: begin rw = 1; end
      11: begin pcw = 1; psrc = 2'b10; end
      default: begin end
    endcase
    return {pcw, pcwc, io, mr, mw, irw, rdst, m2r, rw, asa, asb, aop, psrc,
            ext, ill, 4'(ph)};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: one expected vector per clock cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [23:0] e;
      logic [23:0] a;
      e = exp_q.pop_front();
      a = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, ext_mode, illegal_op, state};
      check("cycle_vec", {8'h0, a}, {8'h0, e});
    end
  end

  // Driver tasks
  task automatic do_reset(input int n, input bit rdy_one);
    reset_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_ready = rdy_one ? 1'b1 : 1'($urandom_range(0, 1));
      opcode    = 6'($urandom);
      exp_q.push_back(exp_vec(0, opcode, mem_ready, 1'b1));
      @(posedge clk); #1;
    end
    reset_n = 1'b1;
  endtask

  // Runs one instruction from FETCH entry. fstall and mstall give the number
  // of mem_ready=0 cycles in FETCH and in MEMRD/MEMWR. With abort_wb set, reset
  // is pulsed in the middle of the MEMWB cycle of a load.
  task automatic run_instr(input logic [5:0] op, input int fstall,
                           input int mstall, input bit abort_wb);
    int ph[$];
    bit rq[$];
    for (int i = 0; i < fstall; i++) begin ph.push_back(0); rq.push_back(0); end
    ph.push_back(0); rq.push_back(1);
    ph.push_back(1); rq.push_back(1'($urandom_range(0, 1)));
    if (is_legal(op)) begin
      case (op)
        6'h23, 6'h2B: begin
          ph.push_back(2); rq.push_back(1'($urandom_range(0, 1)));
          for (int i = 0; i < mstall; i++) begin
            ph.push_back(op == 6'h23 ? 3 : 5); rq.push_back(0);
          end
          ph.push_back(op == 6'h23 ? 3 : 5); rq.push_back(1);
          if (op == 6'h23) begin ph.push_back(4); rq.push_back(1'($urandom_range(0, 1))); end
        end
        6'h00: begin ph.push_back(6); rq.push_back(0); ph.push_back(7); rq.push_back(1); end
        6'h04: begin ph.push_back(8); rq.push_back(0); end
        6'h02: begin ph.push_back(11); rq.push_back(0); end
        default: begin ph.push_back(9); rq.push_back(0); ph.push_back(10); rq.push_back(1); end
      endcase
    end
    for (int i = 0; i < ph.size(); i++) begin
      mem_ready = rq[i];
      opcode    = (ph[i] == 0) ? 6'($urandom) : op;
      exp_q.push_back(exp_vec(ph[i], opcode, mem_ready, 1'b0));
      if (abort_wb && ph[i] == 4) begin
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("abort_reg_write", {31'h0, reg_write}, 32'h0);
        check("abort_state", {28'h0, state}, 32'h0);
        @(posedge clk); #1;
        do_reset(1, 1'b0);
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  logic [5:0] pool[10];

  initial begin
    pool = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02, 6'h0C, 6'h0D, 6'h0F, 6'h3F};
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'h00;
    @(posedge clk); #1;
    do_reset(2, 1'b1);

    run_instr(6'h23, 0, 0, 1'b0);   // lw
    run_instr(6'h2B, 0, 3, 1'b0);   // sw with a 3-cycle write stall
    run_instr(6'h04, 0, 0, 1'b0);   // beq
    run_instr(6'h02, 0, 0, 1'b0);   // j
    run_instr(6'h0D, 0, 0, 1'b0);   // ori, or illegal when the feature is off
    run_instr(6'h00, 2, 0, 1'b0);   // R-type with a fetch stall
    run_instr(6'h08, 0, 0, 1'b0);   // addi
    run_instr(6'h0C, 0, 0, 1'b0);
    run_instr(6'h0F, 0, 0, 1'b0);
    run_instr(6'h3F, 0, 0, 1'b0);   // illegal
    run_instr(6'h23, 1, 2, 1'b0);
    run_instr(6'h23, 0, 0, 1'b1);   // reset during MEMWB

    for (int n = 0; n < 80; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : pool[$urandom_range(0, 9)];
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3),
                (op == 6'h23) && ($urandom_range(0, 5) == 0));
    end

    @(posedge clk); #1;
    @(posedge clk); #1;
    check("queue_drain", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multi-cycle control unit for the MIPS processor core: a registered Moore FSM that sequences instruction fetch, decode, execute, memory access and write-back over the shared ALU, memory port and immediate extender. It decodes the 6-bit opcode held in the instruction register and drives every datapath mux select and write strobe. It also selects the immediate-extender mode, choosing between sign-extend, zero-extend and upper-load. Memory states stall on a ready handshake.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26], stable from DECODE until the next FETCH.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write, pc_write_cond  out  1  unconditional / branch-qualified PC load.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read, mem_write  out  1  memory strobes.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  register-file write address: 0 = rt, 1 = rd.
- mem_to_reg  out  1  register-file write data: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register-file write.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = ext, 11 = ext<<2.
- alu_op  out  3  ALU operation: 000 = add, 001 = sub, 010 = funct, 011 = and, 100 = or, 101 = pass B.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- ext_mode  out  2  extender mode: 00 = sign, 01 = zero, 10 = imm<<16.
- illegal_op  out  1  one-cycle pulse on an undecoded opcode.
- state  out  4  current state, for debug.

## Operation
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, ALUWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11
  - Codes 12–15 are unreachable and return to FETCH.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00.
  - ir_write and pc_write are asserted only when mem_ready=1.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target).
  - Next state by opcode:
    - lw 0x23 / sw 0x2B → MEMADR
    - R-type 0x00 → EXEC
    - beq 0x04 → BRANCH
    - addi 0x08 → IEXEC
    - j 0x02 → JUMP
    - any other opcode → FETCH, with illegal_op=1 for that cycle.
- MEMADR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=000.
  - Next: MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, iord=1; waits for mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; then FETCH.
- MEMWR: mem_write=1, iord=1; waits for mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=010; then ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_src=01; then FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10, alu_op per opcode (see Configuration); then IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
- JUMP: pc_write=1, pc_src=10; then FETCH.
- ext_mode is decoded combinationally from opcode in every state except FETCH, where it is 00.
- Every output not listed for a state is 0.

## Timing
- Reset:
  - state=FETCH immediately on reset_n low.
  - pc_write, ir_write, mem_write, reg_write and illegal_op are forced to 0 while reset_n=0.
  - All other outputs take their FETCH values.
- Reset asserted mid-instruction aborts it; no strobe fires afterward.
- Latency with mem_ready held at 1, counted in cycles from FETCH entry:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 2.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
  - During a stall the memory strobe and iord stay constant.
- mem_ready is sampled only in FETCH, MEMRD and MEMWR; it is ignored in all other states.

## Configuration
- MIPS_LOGIC_IMM_EN defined — three additional opcodes decode in DECODE and go to IEXEC, then IWB:
  - andi 0x0C: alu_op=011, ext_mode=01.
  - ori 0x0D: alu_op=100, ext_mode=01.
  - lui 0x0F: alu_op=101, ext_mode=10.
- MIPS_LOGIC_IMM_EN undefined:
  - 0x0C, 0x0D and 0x0F are illegal (illegal_op pulse, return to FETCH).
  - ext_mode is constant 00.
  - alu_op never takes 011, 100 or 101.
- In both builds addi uses alu_op=000, ext_mode=00.

## Test plan
- Reset, then release with mem_ready=1 → state=0 with all strobes 0 during reset; first cycle after release shows mem_read=1, ir_write=1, pc_write=1, alu_src_b=01.
- lw (0x23) with mem_ready=1 → states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
- sw (0x2B) with mem_ready low for 3 cycles in MEMWR → mem_write=1 and iord=1 for 4 cycles; then FETCH; total 7 cycles.
- beq (0x04), then j (0x02) → pc_write_cond=1 with alu_op=001 in BRANCH; pc_write=1 with pc_src=10 in JUMP; 3 cycles each.
- Opcode 0x0D:
  - With MIPS_LOGIC_IMM_EN defined → IEXEC shows alu_op=100, ext_mode=01; IWB shows reg_write=1.
  - Without it → illegal_op pulses once in DECODE, then FETCH.
- reset_n pulsed low during MEMWB of lw → reg_write drops immediately; state=0 on release.
